// File: rtl/path_delay_probe_pkg.sv
// Shared definitions for the path delay probe: FSM state encoding and parameter defaults.
package path_delay_probe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int CNT_W_DEF       = 8;
  localparam int TIMEOUT_DEF     = 200;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/path_delay_probe_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit; all flops clear on reset.
module bit_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_p <= '0;
    else        sync_p <= {sync_p[DEPTH-2:0], d};
  end

  assign q = sync_p[DEPTH-1];

endmodule

// File: rtl/path_delay_probe.sv
// Round-trip delay probe: toggles launch, counts cycles until the synchronized echo
// matches, and reports the count (or a timeout) through a valid/ready result port.
module path_delay_probe
  import path_delay_probe_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             launch,
  input  logic             echo,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             echo_s;

  // Counter increments but never passes TIMEOUT, so it cannot wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? TIMEOUT_C : v + CNT_W'(1);
  endfunction

  bit_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_echo_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (echo),
    .q     (echo_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      launch      <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A start is only honoured once the path has settled to the current launch level.
          if (start && (echo_s == launch)) begin
            launch <= ~launch;
            count  <= '0;
            busy   <= 1'b1;
            state  <= WAIT;
          end
        end
        WAIT: begin
          // A match is checked first so it wins over a simultaneous timeout.
          if (echo_s == launch) begin
            res_cycles  <= count;
            res_timeout <= 1'b0;
            res_valid   <= 1'b1;
            state       <= REPORT;
          end else if (count == TIMEOUT_C) begin
            res_cycles  <= TIMEOUT_C;
            res_timeout <= 1'b1;
            res_valid   <= 1'b1;
            state       <= REPORT;
          end else begin
            count <= sat_inc(count);
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_path_delay_probe.sv
// Directed bench for path_delay_probe: a table of loopback/delay measurements plus
// hand-written sequences for back-pressure, refused starts and mid-measurement reset.
module tb_path_delay_probe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic       launch;
  logic       echo;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_cycles;
  logic       res_timeout;

  int errors = 0;
  int checks = 0;

  // Echo source: forced level, direct loopback (tap 0) or launch delayed by tap cycles.
  logic       use_force  = 1'b0;
  logic       echo_force = 1'b0;
  int         tap        = 0;
  logic [7:0] dline      = '0;

  always #5 clk = ~clk;

  always @(posedge clk) dline <= {dline[6:0], launch};

  assign echo = use_force ? echo_force : ((tap == 0) ? launch : dline[tap-1]);

  path_delay_probe #(
    .CNT_W       (8),
    .TIMEOUT     (200),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .launch      (launch),
    .echo        (echo),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_cycles  (res_cycles),
    .res_timeout (res_timeout)
  );

  typedef struct {
    int   tap;
    bit   force_lo;
    int   exp_cycles;
    bit   exp_to;
    bit   exp_launch;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input int limit);
    int n = 0;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_seen", res_valid, 1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("valid_drop_after_accept", res_valid, 0);
    check("busy_drop_after_accept", busy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_launch"}, launch, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_cycles"}, res_cycles, 0);
    check({tag, "_res_timeout"}, res_timeout, 0);
  endtask

  initial begin
    // Expected cycles = SYNC_STAGES (2) + extra path delay; timeout row reports 200.
    vecs[0] = '{tap: 5, force_lo: 1'b0, exp_cycles: 7,   exp_to: 1'b0, exp_launch: 1'b1};
    vecs[1] = '{tap: 5, force_lo: 1'b0, exp_cycles: 7,   exp_to: 1'b0, exp_launch: 1'b0};
    vecs[2] = '{tap: 0, force_lo: 1'b0, exp_cycles: 2,   exp_to: 1'b0, exp_launch: 1'b1};
    vecs[3] = '{tap: 1, force_lo: 1'b0, exp_cycles: 3,   exp_to: 1'b0, exp_launch: 1'b0};
    vecs[4] = '{tap: 8, force_lo: 1'b0, exp_cycles: 10,  exp_to: 1'b0, exp_launch: 1'b1};
    vecs[5] = '{tap: 3, force_lo: 1'b0, exp_cycles: 5,   exp_to: 1'b0, exp_launch: 1'b0};
    vecs[6] = '{tap: 0, force_lo: 1'b1, exp_cycles: 200, exp_to: 1'b1, exp_launch: 1'b1};

    rst_n     = 1'b0;
    start     = 1'b0;
    res_ready = 1'b0;
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      use_force  = vecs[i].force_lo;
      echo_force = 1'b0;
      tap        = vecs[i].tap;
      repeat (12) @(negedge clk);
      pulse_start();
      check("busy_after_start", busy, 1);
      wait_valid(400);
      check($sformatf("row%0d_cycles", i), res_cycles, vecs[i].exp_cycles);
      check($sformatf("row%0d_timeout", i), res_timeout, vecs[i].exp_to);
      check($sformatf("row%0d_launch", i), launch, vecs[i].exp_launch);
      accept();
    end

    // Back-pressure: result held while res_ready is low, start in REPORT ignored.
    use_force = 1'b0;
    tap       = 0;
    repeat (6) @(negedge clk);
    pulse_start();
    wait_valid(50);
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", res_valid, 1);
      check("hold_cycles", res_cycles, 2);
      check("hold_timeout", res_timeout, 0);
      check("hold_launch", launch, 0);
      start = (k == 3);
      @(negedge clk);
    end
    start = 1'b0;
    accept();
    check("launch_after_hold", launch, 0);

    // Unsettled path in IDLE: echo high while launch is low, start must be refused.
    use_force  = 1'b1;
    echo_force = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    for (int k = 0; k < 4; k++) begin
      check("refused_busy", busy, 0);
      check("refused_launch", launch, 0);
      check("refused_valid", res_valid, 0);
      @(negedge clk);
    end

    // Reset in the 3rd WAIT cycle aborts the measurement.
    use_force = 1'b0;
    tap       = 5;
    repeat (12) @(negedge clk);
    pulse_start();
    check("pre_reset_busy", busy, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midwait_reset");
    @(negedge clk) rst_n = 1'b1;
    use_force  = 1'b1;
    echo_force = 1'b1;
    repeat (4) @(negedge clk);
    pulse_start();
    check("post_reset_refused_busy", busy, 0);
    check("post_reset_refused_launch", launch, 0);
    repeat (3) @(negedge clk);
    check("post_reset_no_result", res_valid, 0);
    use_force = 1'b0;
    tap       = 0;
    repeat (4) @(negedge clk);
    pulse_start();
    check("post_reset_busy", busy, 1);
    wait_valid(50);
    check("post_reset_cycles", res_cycles, 2);
    check("post_reset_timeout", res_timeout, 0);
    check("post_reset_launch", launch, 1);
    accept();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
